// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target state encoding and PCF8574 backpack bit map
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT
  } i2c_state_e;

  // HD44780 backpack wiring of the expander port
  localparam int PCF_RS = 0;
  localparam int PCF_RW = 1;
  localparam int PCF_E  = 2;
  localparam int PCF_BL = 3;
  localparam int PCF_D4 = 4;
  localparam int PCF_D5 = 5;
  localparam int PCF_D6 = 6;
  localparam int PCF_D7 = 7;

  localparam logic [6:0] PCF_DEFAULT_ADDR = 7'h27;

endpackage

// File: rtl/pcf8574_target_if.sv
// rtl/pcf8574_target_if.sv - I2C pins and parallel port of the PCF8574 target
interface pcf8574_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] p_in;
  logic [7:0] p_out;
  logic       wr_strobe;
  logic       selected;

  modport master (
    output scl_in, sda_in, p_in,
    input  sda_out, p_out, wr_strobe, selected
  );

  modport slave (
    input  scl_in, sda_in, p_in,
    output sda_out, p_out, wr_strobe, selected
  );
endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge, START and STOP pulses
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;

  // Idle bus is high on both lines, so reset to 1 avoids a false edge on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_o      = sda_sync_q[1];
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & ~sda_o & sda_prev_q;
  assign stop_o     = scl_s & scl_prev_q & sda_o & ~sda_prev_q;

endmodule

// File: rtl/pcf8574_target.sv
// rtl/pcf8574_target.sv - I2C target emulating a PCF8574 8-bit I/O expander
module pcf8574_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = PCF_DEFAULT_ADDR,
  parameter logic [7:0] PORT_RST = 8'hFF
) (
  input logic              clk,
  input logic              rst_n,
  pcf8574_target_if.slave  bus
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (bus.scl_in),
    .sda_i     (bus.sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] pout_q, pout_d;
  logic       rw_q, rw_d;
  logic       done_q, done_d;
  logic       sda_q, sda_d;
  logic       stb_q, stb_d;
  logic       sel_q, sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      pout_q  <= PORT_RST;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
      sda_q   <= 1'b1;
      stb_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pout_q  <= pout_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
      sda_q   <= sda_d;
      stb_q   <= stb_d;
      sel_q   <= sel_d;
    end
  end

  // done_q marks "byte/ack bit complete, waiting for the SCL fall that ends it"
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pout_d  = pout_q;
    rw_d    = rw_q;
    done_d  = done_q;
    sda_d   = sda_q;
    stb_d   = 1'b0;
    sel_d   = sel_q;
    if (stop_det) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      sda_d   = 1'b1;
      sel_d   = 1'b0;
    end else if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      sda_d   = 1'b1;
      sel_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (done_q) begin
            if (shift_q[7:1] != ADDR) begin
              state_d = S_WAIT;
              done_d  = 1'b0;
            end else if (scl_fall) begin
              sda_d   = 1'b0;
              rw_d    = shift_q[0];
              done_d  = 1'b0;
              state_d = S_ADDR_ACK;
            end
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            done_d  = (cnt_q == 3'd7);
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            sel_d = 1'b1;
            if (rw_q) begin
              shift_d = bus.p_in;
              sda_d   = bus.p_in[7];
              state_d = S_RD_DATA;
            end else begin
              sda_d   = 1'b1;
              state_d = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (done_q) begin
            if (scl_fall) begin
              sda_d   = 1'b0;
              done_d  = 1'b0;
              state_d = S_WR_ACK;
            end
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              done_d = 1'b1;
              pout_d = {shift_q[6:0], sda_s};
              stb_d  = 1'b1;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            state_d = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            cnt_d  = cnt_q + 3'd1;
            done_d = (cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (done_q) begin
              sda_d   = 1'b1;
              done_d  = 1'b0;
              state_d = S_RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sda_d   = shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_WAIT;
              sel_d   = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            shift_d = bus.p_in;
            sda_d   = bus.p_in[7];
            done_d  = 1'b0;
            state_d = S_RD_DATA;
          end
        end
        S_WAIT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sda_out   = sda_q;
    bus.p_out     = pout_q;
    bus.wr_strobe = stb_q;
    bus.selected  = sel_q;
  end

endmodule

// File: tb/tb_pcf8574_target.sv
// tb/tb_pcf8574_target.sv - self-checking bench for the PCF8574 I2C target
module tb_pcf8574_target;

  localparam logic [6:0] TGT = 7'h27;
  localparam int Q = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_pout = 8'hFF;
  logic prev_stb = 1'b0, prev_sda = 1'b1, prev_rst = 1'b0, sda_low_seen = 1'b0;

  pcf8574_target_if bus();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & bus.sda_out;

  pcf8574_target #(.ADDR(TGT), .PORT_RST(8'hFF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Model of the expander port: queued bytes retire one per strobe
  always @(negedge clk) begin
    if (!rst_n) begin
      model_pout = 8'hFF;
      exp_q.delete();
    end else begin
      if (bus.wr_strobe) begin
        n_strobe++;
        check("strobe_width", prev_stb, 1'b0);
        check("strobe_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) model_pout = exp_q.pop_front();
      end
      check("p_out_model", bus.p_out, model_pout);
      if (prev_rst && bus.sda_out !== prev_sda) check("sda_edge_scl_low", m_scl, 1'b0);
    end
    if (bus.sda_out === 1'b0) sda_low_seen = 1'b1;
    prev_stb = bus.wr_strobe;
    prev_sda = bus.sda_out;
    prev_rst = rst_n;
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q;
    r = bus.sda_in; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, r);
    check(nm, r, exp_ack ? 1'b0 : 1'b1);
  endtask

  task automatic read_bits(output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      v[i] = r;
    end
  endtask

  task automatic wr_txn(input logic [6:0] a, input logic [23:0] d, input int n);
    logic match;
    logic [7:0] b;
    match = (a == TGT);
    i2c_start();
    write_byte({a, 1'b0}, match, "addr_ack");
    check("sel_after_addr", bus.selected, match);
    for (int k = 0; k < n; k++) begin
      b = d[8*(n-1-k) +: 8];
      if (match) exp_q.push_back(b);
      write_byte(b, match, "data_ack");
    end
    check("sel_before_stop", bus.selected, match);
    i2c_stop();
    check("sel_after_stop", bus.selected, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [7:0] v;
    logic r;
    bus.p_in = 8'h00;
    #43;
    check("rst_sda_out", bus.sda_out, 1'b1);
    check("rst_p_out", bus.p_out, 8'hFF);
    check("rst_wr_strobe", bus.wr_strobe, 1'b0);
    check("rst_selected", bus.selected, 1'b0);
    rst_n = 1'b1; #Q;

    // address 0x40 (7'h20) is not ours
    sda_low_seen = 1'b0; s0 = n_strobe;
    wr_txn(7'h20, 24'h000055, 1);
    check("mm_no_sda_low", sda_low_seen, 1'b0);
    check("mm_p_out", bus.p_out, 8'hFF);
    check("mm_strobes", n_strobe - s0, 0);

    s0 = n_strobe;
    wr_txn(TGT, 24'h00003C, 1);
    check("w1_p_out", bus.p_out, 8'h3C);
    check("w1_strobes", n_strobe - s0, 1);

    s0 = n_strobe;
    wr_txn(TGT, 24'h3C382C, 3);
    check("w3_p_out", bus.p_out, 8'h2C);
    check("w3_strobes", n_strobe - s0, 3);

    s0 = n_strobe;
    bus.p_in = 8'hA5;
    i2c_start();
    write_byte(8'h4F, 1'b1, "rd_addr_ack");
    check("rd_sel", bus.selected, 1'b1);
    read_bits(v);
    bus.p_in = 8'h5A;
    xfer_bit(1'b0, r);
    check("rd_byte0", v, 8'hA5);
    read_bits(v);
    xfer_bit(1'b1, r);
    check("rd_byte1", v, 8'h5A);
    check("rd_nack_sel", bus.selected, 1'b0);
    check("rd_nack_sda", bus.sda_out, 1'b1);
    i2c_stop();
    check("rd_p_out", bus.p_out, 8'h2C);
    check("rd_strobes", n_strobe - s0, 0);

    s0 = n_strobe;
    i2c_start();
    write_byte(8'h4E, 1'b1, "ab_addr_ack");
    xfer_bit(1'b1, r); xfer_bit(1'b0, r); xfer_bit(1'b0, r); xfer_bit(1'b0, r);
    wr_txn(TGT, 24'h000081, 1);
    check("ab_p_out", bus.p_out, 8'h81);
    check("ab_strobes", n_strobe - s0, 1);

    i2c_start();
    for (int i = 7; i >= 0; i--) xfer_bit(((8'h4E >> i) & 8'h01) != 0, r);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    check("rs_ack_driven", bus.sda_out, 1'b0);
    rst_n = 1'b0; #1;
    check("rs_sda_async", bus.sda_out, 1'b1);
    check("rs_p_out", bus.p_out, 8'hFF);
    check("rs_selected", bus.selected, 1'b0);
    #(Q-1);
    m_scl = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    rst_n = 1'b1; #Q;
    s0 = n_strobe;
    wr_txn(TGT, 24'h000038, 1);
    check("rs_after_p_out", bus.p_out, 8'h38);
    check("rs_after_strobes", n_strobe - s0, 1);

    #Q;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
